// File: rtl/rv_trace_pkg.sv
// Shared types for the commit-trace capture block.
// Fixed field widths and the packed trace record layout.
// Memory-event kinds use the {WriteEnable, ReadEnable} bit pattern directly.
package rv_trace_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 9;
  localparam int REG_W  = 5;
  localparam int TS_W   = 32;
  localparam int OVF_W  = 16;

  // Encoding equals {WriteEnable, ReadEnable} so decode is a plain cast.
  typedef enum logic [1:0] {
    NONE     = 2'b00,
    READ     = 2'b01,
    WRITE    = 2'b10,
    CONFLICT = 2'b11
  } mem_kind_t;

  typedef struct packed {
    logic [TS_W-1:0]   ts;
    logic              lost;
    logic              reg_vld;
    logic [REG_W-1:0]  reg_num;
    logic [DATA_W-1:0] reg_data;
    mem_kind_t         mem_kind;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
  } trace_rec_t;

  localparam int REC_W = $bits(trace_rec_t);

  function automatic mem_kind_t decode_mem_kind(input logic we, input logic re);
    return mem_kind_t'({we, re});
  endfunction

endpackage

// File: rtl/rv_trace_buffer_if.sv
// Trace record output stream (valid/ready, record held stable while stalled).
// Producer side is the trace buffer, consumer side the drain logic.
// No storage; pure signal bundle.
interface rv_trace_buffer_if
  import rv_trace_pkg::*;
  ;
  logic       tr_valid;
  logic       tr_ready;
  trace_rec_t tr_data;

  modport master (output tr_valid, output tr_data, input tr_ready);
  modport slave  (input tr_valid, input tr_data, output tr_ready);

endinterface

// File: rtl/trace_fifo.sv
// Generic synchronous first-word-fall-through FIFO with flush and occupancy count.
// Latency: a word written at edge N is visible on rd_dat_o from N+1.
// Backpressure: wr_rdy_o low only when full and no read this cycle; flush wins over read/write.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     wr_vld_i,
  output logic                     wr_rdy_o,
  input  logic [WIDTH-1:0]         wr_dat_i,
  output logic                     rd_vld_o,
  input  logic                     rd_rdy_i,
  output logic [WIDTH-1:0]         rd_dat_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             empty, full, do_wr, do_rd;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign do_rd    = rd_rdy_i & ~empty;
  // A read in the same cycle frees a slot, so a full FIFO can still accept.
  assign wr_rdy_o = ~full | do_rd;
  assign do_wr    = wr_vld_i & wr_rdy_o;

  assign rd_vld_o = ~empty;
  // Output forced to zero while empty so the stream carries no stale data.
  assign rd_dat_o = empty ? '0 : mem[rd_ptr_q];
  assign count_o  = count_q;

  // Next pointers and occupancy; flush empties the FIFO outright.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_wr && !flush_i) mem[wr_ptr_q] <= wr_dat_i;
  end

endmodule

// File: rtl/rv_trace_buffer.sv
// Captures core reg-write / data-memory activity into timestamped records, buffered and streamed out.
// Latency: event sampled at edge N appears on tr_valid/tr_data from N+1 (no bypass path).
// Backpressure: tr_ready low stalls the stream; when full, new records are dropped and counted.
module rv_trace_buffer
  import rv_trace_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter bit SKIP_X0 = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   trace_en,
  input  logic                   trace_clr,
  input  logic [2:0]             cap_mask,
  input  logic                   RegWriteSignal,
  input  logic [REG_W-1:0]       RegNum,
  input  logic [DATA_W-1:0]      RegData,
  input  logic                   WriteEnable,
  input  logic                   ReadEnable,
  input  logic [ADDR_W-1:0]      Address,
  input  logic [DATA_W-1:0]      WriteData,
  input  logic [DATA_W-1:0]      ReadData,
  rv_trace_buffer_if.master      tr,
  output logic [$clog2(DEPTH):0] level,
  output logic [OVF_W-1:0]       ovf_cnt,
  output logic                   err_conflict
);

  logic [TS_W-1:0]  ts_q, ts_d;
  logic [OVF_W-1:0] ovf_q, ovf_d;
  logic             lost_q, lost_d;
  logic             conflict_q, conflict_d;

  logic             reg_ev, mem_ev, push;
  logic             fifo_wr_rdy, accept, drop;
  mem_kind_t        kind;
  trace_rec_t       rec;
  logic [REC_W-1:0] fifo_rd_dat;

  assign kind   = decode_mem_kind(WriteEnable, ReadEnable);
  assign reg_ev = RegWriteSignal & cap_mask[0] & ~(SKIP_X0 && (RegNum == '0));
  // Conflicts bypass the mask so a bus fault is never silently filtered.
  assign mem_ev = ((kind == WRITE) & cap_mask[1]) |
                  ((kind == READ)  & cap_mask[2]) |
                  (kind == CONFLICT);
  assign push   = trace_en & (reg_ev | mem_ev);
  assign accept = push & fifo_wr_rdy & ~trace_clr;
  assign drop   = push & ~fifo_wr_rdy & ~trace_clr;

  // Assemble the record; fields of a class that did not fire stay zero.
  always_comb begin
    rec      = '0;
    rec.ts   = ts_q;
    rec.lost = lost_q;
    if (reg_ev) begin
      rec.reg_vld  = 1'b1;
      rec.reg_num  = RegNum;
      rec.reg_data = RegData;
    end
    if (mem_ev) begin
      rec.mem_kind = kind;
      rec.mem_addr = Address;
      rec.mem_data = (kind == READ) ? ReadData : WriteData;
    end
  end

  // Next-state for timestamp, overflow count, lost flag and sticky conflict.
  always_comb begin
    ts_d       = ts_q + TS_W'(1);
    ovf_d      = ovf_q;
    lost_d     = lost_q;
    conflict_d = conflict_q;
    if (trace_clr) begin
      ovf_d      = '0;
      lost_d     = 1'b0;
      conflict_d = 1'b0;
    end else begin
      if (kind == CONFLICT) conflict_d = 1'b1;
      // The lost bit has just been carried by an accepted record.
      if (accept) lost_d = 1'b0;
      if (drop) begin
        lost_d = 1'b1;
        if (ovf_q != '1) ovf_d = ovf_q + OVF_W'(1);
      end
    end
  end

  // Status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_q       <= '0;
      ovf_q      <= '0;
      lost_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      ts_q       <= ts_d;
      ovf_q      <= ovf_d;
      lost_q     <= lost_d;
      conflict_q <= conflict_d;
    end
  end

  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst),
    .flush_i  (trace_clr),
    .wr_vld_i (accept),
    .wr_rdy_o (fifo_wr_rdy),
    .wr_dat_i (rec),
    .rd_vld_o (tr.tr_valid),
    .rd_rdy_i (tr.tr_ready & ~trace_clr),
    .rd_dat_o (fifo_rd_dat),
    .count_o  (level)
  );

  assign tr.tr_data   = trace_rec_t'(fifo_rd_dat);
  assign ovf_cnt      = ovf_q;
  assign err_conflict = conflict_q;

endmodule
